zx_kbd_matrix: RTL and testbench
================================

ZX_KBD_MATRIX -- requirements
Module: zx_kbd_matrix

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ps2_data  in  8  scancode byte from the PS/2 receiver
- ps2_data_en  in  1  one-cycle strobe; ps2_data valid
- A  in  16  Z80 address bus; only A[15:8] used (half-row select, active-low)
- D  out  8  port FEh read data
- key_any  out  1  high while any matrix key is held

Function
REQ-003 The block SHALL hold a 40-bit key state: 8 rows x 5 bits; 1 = pressed.
REQ-004 The matrix rows SHALL be:
- row0 CS,Z,X,C,V
- row1 A,S,D,F,G
- row2 Q,W,E,R,T
- row3 1,2,3,4,5
- row4 0,9,8,7,6
- row5 P,O,I,U,Y
- row6 ENT,L,K,J,H
- row7 SP,SS,M,N,B
- Bit0 is the first key listed in each row.
REQ-005 Letters and digits SHALL use PS/2 set-2 codes; examples: 1Ch=A (row1 bit0), 16h=1 (row3 bit0), 45h=0 (row4 bit0), 5Ah=ENT, 29h=SP, 12h/59h=CS, 14h=SS.
REQ-006 The decoder FSM SHALL advance only on ps2_data_en and SHALL have four states: IDLE, BRK, EXT, EXT_BRK.
REQ-007 FSM transitions SHALL be:
- IDLE: F0h->BRK; E0h->EXT; mapped code->set bit, stay IDLE; other->IDLE.
- BRK: mapped code->clear bit; any byte->IDLE.
- EXT: F0h->EXT_BRK; other byte->extended make (REQ-015), then IDLE.
- EXT_BRK: any byte->extended release (REQ-015), then IDLE.
REQ-008 Unmapped codes (including FAh, AAh, E1h) SHALL leave the matrix unchanged.
REQ-009 A matrix bit update SHALL be visible in the matrix register on the clock edge after the strobe.
REQ-010 Repeated make codes SHALL be idempotent.
REQ-011 D SHALL be a register updated every clk:
- D[7:5] = 3'b111.
- D[4:0] = ~(OR of row[r] over every r where A[8+r]==0).
- If no row is selected, D[4:0] = 5'b11111.
- D reflects A and the matrix from the previous cycle (1-cycle latency).
REQ-012 key_any SHALL be registered and equal to the OR of all 40 bits.
REQ-013 A strobe arriving in the same cycle as reset SHALL be discarded.

Reset
REQ-014 On reset the block SHALL enter this state:
- FSM = IDLE.
- Matrix and virtual-key register = 0.
- D = 8'hFF.
- key_any = 0.
- Any prefix received before reset is forgotten, so a following byte is treated as a make.

Configuration
REQ-015 The macro ZX_KBD_EXT_KEYS_EN SHALL control compound keys.
- Defined: a 5-bit virtual-key register tracks E0 6Bh (left -> CS+5), E0 72h (down -> CS+6), E0 75h (up -> CS+7), E0 74h (right -> CS+8) and 66h (backspace -> CS+0).
- Defined: effective CS = physical CS OR any virtual bit.
- Defined: the effective digit bit = physical digit OR its virtual bit.
- Defined: releasing a virtual key does not clear a physically held CS or digit.
- Not defined: all E0-prefixed codes other than E0 12h/14h/59h are ignored; the prefix is still consumed; 66h is unmapped.
- E0 14h (right Ctrl) SHALL map to SS in both builds.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset, then A=FDFEh -> D=FFh and key_any=0.
- Strobe 1Ch; set A=FDFEh -> D=FEh after 2 cycles; then F0h,1Ch -> D=FFh and key_any=0.
- Press 12h and 2Ah (V); A=FEFEh -> D=EEh; A=7FFEh -> D=FFh; A=7EFEh -> D=EEh.
- With the macro defined: E0h,6Bh -> A=FEFEh gives D=FEh and A=F7FEh gives D=EFh; then hold 12h and send E0h,F0h,6Bh -> A=FEFEh still gives D=FEh.
- Without the macro: E0h,6Bh -> D=FFh on every row; the next byte 1Ch is still decoded as a make of A.
- Send F0h, assert reset, then send 1Ch -> A key pressed (D=FEh at A=FDFEh); a strobe coincident with reset is ignored.

Source files
------------

// File: rtl/zx_kbd_matrix.sv
// zx_kbd_matrix: PS/2 set-2 scancode to ZX Spectrum 8x5 keyboard matrix.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   ps2_data     scancode byte from the PS/2 receiver
//   ps2_data_en  one-cycle strobe, ps2_data valid
//   A            Z80 address bus; A[15:8] select half-rows (active-low)
//   D            registered port FEh read data ({3'b111, active-low columns})
//   key_any      registered, high while any matrix key is held
//
// Build option: define ZX_KBD_EXT_KEYS_EN to enable the compound keys (cursor keys
// and backspace), which press CAPS SHIFT together with a digit.
module zx_kbd_matrix (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_data_en,
    input  logic [15:0] A,
    output logic [7:0]  D,
    output logic        key_any
);

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic key_pos_t pos(input logic [2:0] row, input logic [2:0] col);
        key_pos_t p;
        p.hit = 1'b1;
        p.row = row;
        p.col = col;
        return p;
    endfunction

    // Unprefixed set-2 codes.
    function automatic key_pos_t map_code(input logic [7:0] code);
        unique case (code)
            8'h12, 8'h59: return pos(3'd0, 3'd0);  // CAPS SHIFT (either shift)
            8'h1A: return pos(3'd0, 3'd1);
            8'h22: return pos(3'd0, 3'd2);
            8'h21: return pos(3'd0, 3'd3);
            8'h2A: return pos(3'd0, 3'd4);
            8'h1C: return pos(3'd1, 3'd0);
            8'h1B: return pos(3'd1, 3'd1);
            8'h23: return pos(3'd1, 3'd2);
            8'h2B: return pos(3'd1, 3'd3);
            8'h34: return pos(3'd1, 3'd4);
            8'h15: return pos(3'd2, 3'd0);
            8'h1D: return pos(3'd2, 3'd1);
            8'h24: return pos(3'd2, 3'd2);
            8'h2D: return pos(3'd2, 3'd3);
            8'h2C: return pos(3'd2, 3'd4);
            8'h16: return pos(3'd3, 3'd0);
            8'h1E: return pos(3'd3, 3'd1);
            8'h26: return pos(3'd3, 3'd2);
            8'h25: return pos(3'd3, 3'd3);
            8'h2E: return pos(3'd3, 3'd4);
            8'h45: return pos(3'd4, 3'd0);
            8'h46: return pos(3'd4, 3'd1);
            8'h3E: return pos(3'd4, 3'd2);
            8'h3D: return pos(3'd4, 3'd3);
            8'h36: return pos(3'd4, 3'd4);
            8'h4D: return pos(3'd5, 3'd0);
            8'h44: return pos(3'd5, 3'd1);
            8'h43: return pos(3'd5, 3'd2);
            8'h3C: return pos(3'd5, 3'd3);
            8'h35: return pos(3'd5, 3'd4);
            8'h5A: return pos(3'd6, 3'd0);
            8'h4B: return pos(3'd6, 3'd1);
            8'h42: return pos(3'd6, 3'd2);
            8'h3B: return pos(3'd6, 3'd3);
            8'h33: return pos(3'd6, 3'd4);
            8'h29: return pos(3'd7, 3'd0);
            8'h14: return pos(3'd7, 3'd1);  // left Ctrl -> SYMBOL SHIFT
            8'h3A: return pos(3'd7, 3'd2);
            8'h31: return pos(3'd7, 3'd3);
            8'h32: return pos(3'd7, 3'd4);
            default: return '0;
        endcase
    endfunction

    // E0-prefixed codes that land on physical matrix keys (right shift/ctrl variants).
    function automatic key_pos_t map_ext(input logic [7:0] code);
        unique case (code)
            8'h12, 8'h59: return pos(3'd0, 3'd0);
            8'h14:        return pos(3'd7, 3'd1);
            default:      return '0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [7:0][4:0]     matrix_q, matrix_d;
    logic [7:0]          d_q, d_d;
    logic                key_any_q, key_any_d;
    key_pos_t            code_pos, ext_pos;
    logic [7:0][4:0]     eff;
    logic [4:0]          sel_or;

`ifdef ZX_KBD_EXT_KEYS_EN
    // Virtual keys: left, down, up, right (E0-prefixed), backspace (unprefixed 66h).
    localparam int unsigned VkLeft  = 0;
    localparam int unsigned VkDown  = 1;
    localparam int unsigned VkUp    = 2;
    localparam int unsigned VkRight = 3;
    localparam int unsigned VkBksp  = 4;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } vk_sel_t;

    function automatic vk_sel_t map_ext_vk(input logic [7:0] code);
        vk_sel_t v;
        v.hit = 1'b1;
        unique case (code)
            8'h6B:   v.idx = 3'(VkLeft);
            8'h72:   v.idx = 3'(VkDown);
            8'h75:   v.idx = 3'(VkUp);
            8'h74:   v.idx = 3'(VkRight);
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [4:0] vk_q, vk_d;
    vk_sel_t    ext_vk;
`endif

    // Only the high address byte selects half-rows.
    logic unused_addr_lo;
    assign unused_addr_lo = ^A[7:0];

    // Scancode decoder and matrix next state.
    always_comb begin
        state_d  = state_q;
        matrix_d = matrix_q;
        code_pos = map_code(ps2_data);
        ext_pos  = map_ext(ps2_data);
`ifdef ZX_KBD_EXT_KEYS_EN
        vk_d     = vk_q;
        ext_vk   = map_ext_vk(ps2_data);
`endif
        if (ps2_data_en) begin
            unique case (state_q)
                StIdle: begin
                    if (ps2_data == 8'hF0) begin
                        state_d = StBrk;
                    end else if (ps2_data == 8'hE0) begin
                        state_d = StExt;
                    end else begin
                        if (code_pos.hit) matrix_d[code_pos.row][code_pos.col] = 1'b1;
`ifdef ZX_KBD_EXT_KEYS_EN
                        if (ps2_data == 8'h66) vk_d[VkBksp] = 1'b1;
`endif
                    end
                end
                StBrk: begin
                    if (code_pos.hit) matrix_d[code_pos.row][code_pos.col] = 1'b0;
`ifdef ZX_KBD_EXT_KEYS_EN
                    if (ps2_data == 8'h66) vk_d[VkBksp] = 1'b0;
`endif
                    state_d = StIdle;
                end
                StExt: begin
                    if (ps2_data == 8'hF0) begin
                        state_d = StExtBrk;
                    end else begin
                        if (ext_pos.hit) matrix_d[ext_pos.row][ext_pos.col] = 1'b1;
`ifdef ZX_KBD_EXT_KEYS_EN
                        if (ext_vk.hit) vk_d[ext_vk.idx] = 1'b1;
`endif
                        state_d = StIdle;
                    end
                end
                StExtBrk: begin
                    if (ext_pos.hit) matrix_d[ext_pos.row][ext_pos.col] = 1'b0;
`ifdef ZX_KBD_EXT_KEYS_EN
                    if (ext_vk.hit) vk_d[ext_vk.idx] = 1'b0;
`endif
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Effective matrix (physical keys merged with virtual ones) and port read data.
    always_comb begin
        eff = matrix_q;
`ifdef ZX_KBD_EXT_KEYS_EN
        eff[0][0] = eff[0][0] | (|vk_q);         // CAPS SHIFT
        eff[3][4] = eff[3][4] | vk_q[VkLeft];    // 5
        eff[4][4] = eff[4][4] | vk_q[VkDown];    // 6
        eff[4][3] = eff[4][3] | vk_q[VkUp];      // 7
        eff[4][2] = eff[4][2] | vk_q[VkRight];   // 8
        eff[4][0] = eff[4][0] | vk_q[VkBksp];    // 0
`endif
        sel_or = '0;
        for (int r = 0; r < 8; r++) begin
            if (!A[8+r]) sel_or = sel_or | eff[r];
        end
        d_d       = {3'b111, ~sel_or};
        key_any_d = |eff;
    end

    // Reset wins over a coincident strobe, so that byte is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            matrix_q  <= '0;
            d_q       <= 8'hFF;
            key_any_q <= 1'b0;
`ifdef ZX_KBD_EXT_KEYS_EN
            vk_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            matrix_q  <= matrix_d;
            d_q       <= d_d;
            key_any_q <= key_any_d;
`ifdef ZX_KBD_EXT_KEYS_EN
            vk_q      <= vk_d;
`endif
        end
    end

    assign D       = d_q;
    assign key_any = key_any_q;

endmodule

// File: tb/tb_zx_kbd_matrix.sv
// Testbench for zx_kbd_matrix: directed scenarios followed by random scancode
// streams checked against a key-set model of the Spectrum keyboard.
module tb_zx_kbd_matrix;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ps2_data = 8'h00;
    logic        ps2_data_en = 1'b0;
    logic [15:0] A = 16'hFFFF;
    logic [7:0]  D;
    logic        key_any;

    int checks = 0;
    int errors = 0;

    zx_kbd_matrix dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_data    (ps2_data),
        .ps2_data_en (ps2_data_en),
        .A           (A),
        .D           (D),
        .key_any     (key_any)
    );

    always #5 clk = ~clk;

    // Keyboard layout: index = row*5 + bit.
    logic [7:0] key_code [40] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h14, 8'h3A, 8'h31, 8'h32
    };
    // Digit each virtual key (left, down, up, right, backspace) presses with CS.
    int vk_target [5] = '{19, 24, 23, 22, 20};

    bit pressed [40];
    bit vk [5];
    bit m_brk;
    bit m_ext;

    function automatic int find_key(input logic [7:0] code);
        if (code == 8'h59) return 0;
        for (int i = 0; i < 40; i++) begin
            if (key_code[i] == code) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 40; i++) pressed[i] = 1'b0;
        for (int i = 0; i < 5; i++) vk[i] = 1'b0;
        m_brk = 1'b0;
        m_ext = 1'b0;
    endfunction

    function automatic void apply(input logic [7:0] code, input bit ext, input bit make);
        int k;
        int v;
        k = -1;
        v = -1;
        if (!ext) begin
            k = find_key(code);
`ifdef ZX_KBD_EXT_KEYS_EN
            if (code == 8'h66) v = 4;
`endif
        end else begin
            if (code == 8'h12 || code == 8'h59 || code == 8'h14) k = find_key(code);
`ifdef ZX_KBD_EXT_KEYS_EN
            case (code)
                8'h6B: v = 0;
                8'h72: v = 1;
                8'h75: v = 2;
                8'h74: v = 3;
                default: v = -1;
            endcase
`endif
        end
        if (k >= 0) pressed[k] = make;
        if (v >= 0) vk[v] = make;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_ext && !m_brk) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE0) m_ext = 1'b1;
            else apply(b, 1'b0, 1'b1);
        end else if (m_ext && !m_brk && b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            apply(b, m_ext, !m_brk);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic bit key_down(input int idx);
        bit any_vk;
        any_vk = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (vk[j]) any_vk = 1'b1;
            if (vk[j] && vk_target[j] == idx) return 1'b1;
        end
        if (idx == 0 && any_vk) return 1'b1;
        return pressed[idx];
    endfunction

    function automatic logic [7:0] exp_d(input logic [15:0] a);
        logic [4:0] cols;
        cols = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (!a[8+r] && key_down(r * 5 + c)) cols[c] = 1'b0;
            end
        end
        return {3'b111, cols};
    endfunction

    function automatic logic exp_any();
        for (int i = 0; i < 40; i++) begin
            if (key_down(i)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ps2_data    = b;
        ps2_data_en = 1'b1;
        @(negedge clk);
        ps2_data_en = 1'b0;
        model_byte(b);
    endtask

    // One-cycle reset, optionally with a strobe in the same cycle (must be dropped).
    task automatic do_reset(input bit with_strobe, input logic [7:0] b);
        @(negedge clk);
        reset       = 1'b1;
        ps2_data    = b;
        ps2_data_en = with_strobe;
        @(negedge clk);
        reset       = 1'b0;
        ps2_data_en = 1'b0;
        model_reset();
    endtask

    task automatic look(input logic [15:0] a);
        @(negedge clk);
        A = a;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        model_reset();

        // Reset state.
        do_reset(1'b0, 8'h00);
        check8("reset_d", D, 8'hFF);
        check1("reset_any", key_any, 1'b0);
        look(16'hFDFE);
        check8("idle_d_row1", D, 8'hFF);
        check1("idle_any", key_any, 1'b0);

        // Single key make/break.
        send(8'h1C);
        look(16'hFDFE);
        check8("a_make_d", D, 8'hFE);
        check1("a_make_any", key_any, 1'b1);
        send(8'h1C);  // repeated make is idempotent
        send(8'hF0);
        send(8'h1C);
        look(16'hFDFE);
        check8("a_break_d", D, 8'hFF);
        check1("a_break_any", key_any, 1'b0);

        // Two keys on row 0, multi-row selection.
        send(8'h12);
        send(8'h2A);
        look(16'hFEFE);
        check8("cs_v_row0", D, 8'hEE);
        look(16'h7FFE);
        check8("cs_v_row7", D, 8'hFF);
        look(16'h7EFE);
        check8("cs_v_row07", D, 8'hEE);
        look(16'hFFFE);
        check8("no_row_sel", D, 8'hFF);
        look(16'h0000);
        do_reset(1'b0, 8'h00);
        check8("reset_clears_d", D, 8'hFF);
        check1("reset_clears_any", key_any, 1'b0);

        // Unmapped codes.
        send(8'hFA);
        send(8'hAA);
        send(8'hE1);
        look(16'h0000);
        check8("unmapped_d", D, 8'hFF);

        // Right Ctrl maps to SYMBOL SHIFT in both builds.
        send(8'hE0);
        send(8'h14);
        look(16'h7FFE);
        check8("rctrl_ss", D, 8'hFD);
        send(8'hE0);
        send(8'hF0);
        send(8'h14);
        look(16'h7FFE);
        check8("rctrl_ss_rel", D, 8'hFF);

`ifdef ZX_KBD_EXT_KEYS_EN
        send(8'hE0);
        send(8'h6B);
        look(16'hFEFE);
        check8("left_cs", D, 8'hFE);
        look(16'hF7FE);
        check8("left_5", D, 8'hEF);
        check1("left_any", key_any, 1'b1);
        send(8'h12);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        look(16'hFEFE);
        check8("left_rel_cs_held", D, 8'hFE);
        look(16'hF7FE);
        check8("left_rel_5", D, 8'hFF);
        send(8'hF0);
        send(8'h12);
        send(8'h66);
        look(16'hEFFE);
        check8("bksp_0", D, 8'hFE);
        send(8'hF0);
        send(8'h66);
        look(16'h0000);
        check8("bksp_rel", D, 8'hFF);
`else
        send(8'hE0);
        send(8'h6B);
        look(16'h0000);
        check8("ext_ignored_d", D, 8'hFF);
        check1("ext_ignored_any", key_any, 1'b0);
        send(8'h1C);
        look(16'hFDFE);
        check8("after_ext_make", D, 8'hFE);
        send(8'hF0);
        send(8'h1C);
        send(8'h66);
        look(16'h0000);
        check8("bksp_unmapped", D, 8'hFF);
`endif

        // Pending break prefix forgotten on reset; coincident strobe dropped.
        send(8'hF0);
        do_reset(1'b1, 8'h2A);
        send(8'h1C);
        look(16'hFDFE);
        check8("post_reset_make", D, 8'hFE);
        look(16'hFEFE);
        check8("reset_strobe_drop", D, 8'hFF);

        // Random scancode streams against the model.
        begin
            logic [7:0] pool [25] = '{
                8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'h12, 8'h59, 8'h14, 8'h1C,
                8'h2A, 8'h16, 8'h45, 8'h5A, 8'h29, 8'h32, 8'h2E, 8'h36, 8'h66,
                8'h6B, 8'h72, 8'h75, 8'h74, 8'hFA, 8'hAA, 8'hE1
            };
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 39) == 0) do_reset(1'b1, pool[$urandom_range(0, 24)]);
                else send(pool[$urandom_range(0, 24)]);
                a = 16'($urandom);
                if ($urandom_range(0, 1) == 1) a[15:8] = ~(8'd1 << $urandom_range(0, 7));
                look(a);
                check8("rand_d", D, exp_d(a));
                check1("rand_any", key_any, exp_any());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
